// File: rtl/wb_stage.sv
// wb_stage -- MEM/WB pipeline register and writeback selection.
//
// Captures the MEM-stage instruction, PC, ALU result and data-memory word
// each clock (unless held), decodes the destination register, selects the
// write data and drives the register-file write port.  Also counts retired
// instructions for trace and CPI checks.
//
// Optional feature: define WB_SUBWORD_LOAD_EN to enable lb/lbu/lh/lhu
// writeback with byte/halfword extraction.  Without it those opcodes do
// not write but still retire.
//
// Parameters:
//   CNT_W     width of retire_cnt (wraps modulo 2^CNT_W)
//   LINK_OFS  byte offset added to the PC for jal/jalr link writes
//
// Ports:
//   clk         clock, posedge
//   reset       asynchronous, active-high
//   IR_M        instruction in MEM stage
//   PC_M        PC of IR_M
//   ALUOut_M    ALU result / address of IR_M
//   DMOut_M     data-memory read word for IR_M
//   valid_M     1 = IR_M is a real instruction, 0 = bubble
//   hold_W      1 = W register keeps its contents this cycle
//   IR_W        instruction in W stage
//   WPC         PC of IR_W
//   RegWr       register-file write enable
//   RW          destination register number
//   BusW        write data
//   retire_cnt  instructions retired since reset
module wb_stage #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] LINK_OFS = 32'd8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_M,
  input  logic [31:0]      PC_M,
  input  logic [31:0]      ALUOut_M,
  input  logic [31:0]      DMOut_M,
  input  logic             valid_M,
  input  logic             hold_W,
  output logic [31:0]      IR_W,
  output logic [31:0]      WPC,
  output logic             RegWr,
  output logic [4:0]       RW,
  output logic [31:0]      BusW,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
`ifdef WB_SUBWORD_LOAD_EN
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
`endif

  logic [31:0] ir_w;
  logic [31:0] pc_w;
  logic [31:0] alu_w;
  logic [31:0] dm_w;
  logic        valid_w;
  logic        done_w;   // instruction already had its write/retire cycle

  logic        first_w;  // first W cycle of a real instruction
  logic        wr_class;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] link;

  // W pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_w    <= '0;
      pc_w    <= '0;
      alu_w   <= '0;
      dm_w    <= '0;
      valid_w <= 1'b0;
      done_w  <= 1'b0;
    end else if (hold_W) begin
      // A held instruction consumes its write in the first cycle only.
      if (valid_w) done_w <= 1'b1;
    end else begin
      ir_w    <= IR_M;
      pc_w    <= PC_M;
      alu_w   <= ALUOut_M;
      dm_w    <= DMOut_M;
      valid_w <= valid_M;
      done_w  <= 1'b0;
    end
  end

  // Retire counter: one count per instruction, at the end of its first W cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (first_w) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign first_w = valid_w & ~done_w;
  assign op      = ir_w[31:26];
  assign fn      = ir_w[5:0];
  assign rt      = ir_w[20:16];
  assign rd      = ir_w[15:11];
  assign link    = pc_w + LINK_OFS;

`ifdef WB_SUBWORD_LOAD_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = '0;
    case (alu_w[1:0])
      2'b00:   ld_byte = dm_w[7:0];
      2'b01:   ld_byte = dm_w[15:8];
      2'b10:   ld_byte = dm_w[23:16];
      default: ld_byte = dm_w[31:24];
    endcase
    ld_half = alu_w[1] ? dm_w[31:16] : dm_w[15:0];
  end
`endif

  // Destination / write-data decode
  always_comb begin
    wr_class = 1'b0;
    RW       = rt;
    BusW     = alu_w;
    casez (op)
      OP_RTYPE: begin
        RW = rd;
        if (fn == FN_JALR) begin
          wr_class = 1'b1;
          BusW     = link;
        end else if (fn != FN_JR) begin
          wr_class = 1'b1;
        end
      end
      6'b001???: begin
        wr_class = 1'b1;
      end
      OP_LW: begin
        wr_class = 1'b1;
        BusW     = dm_w;
      end
      OP_JAL: begin
        wr_class = 1'b1;
        RW       = 5'd31;
        BusW     = link;
      end
`ifdef WB_SUBWORD_LOAD_EN
      OP_LB: begin
        wr_class = 1'b1;
        BusW     = {{24{ld_byte[7]}}, ld_byte};
      end
      OP_LBU: begin
        wr_class = 1'b1;
        BusW     = {24'h000000, ld_byte};
      end
      OP_LH: begin
        wr_class = 1'b1;
        BusW     = {{16{ld_half[15]}}, ld_half};
      end
      OP_LHU: begin
        wr_class = 1'b1;
        BusW     = {16'h0000, ld_half};
      end
`endif
      default: begin
        wr_class = 1'b0;
      end
    endcase
  end

  assign RegWr = first_w & wr_class & (RW != 5'd0);
  assign IR_W  = ir_w;
  assign WPC   = pc_w;

endmodule
